// File: rtl/uart_dbg_pkg.sv
// uart_dbg_pkg: command bytes, reply bytes and controller states shared by the UART debug unit
package uart_dbg_pkg;
    localparam logic [7:0] CMD_LOAD  = 8'h01;
    localparam logic [7:0] CMD_RUN   = 8'h02;
    localparam logic [7:0] CMD_STEP  = 8'h03;
    localparam logic [7:0] CMD_NEXT  = 8'h04;
    localparam logic [7:0] CMD_END   = 8'h05;
    localparam logic [7:0] ACK_BYTE  = 8'hA5;
    localparam logic [7:0] DUMP_TERM = 8'h5A;
    typedef enum logic [3:0] {
        IDLE, LD_SIZE, LD_BYTE, LD_WRITE, LD_ACK, RUN, DBG, STEP,
        DUMP_FETCH, DUMP_SEND, DUMP_END
    } state_e;
endpackage

// File: rtl/uart_debug_unit_word_serializer.sv
// word_serializer: shifts a word out LSB byte first into the TX FIFO, respecting the full flag
module word_serializer #(
    parameter int DATA_W = 8,
    parameter int W      = 32,
    parameter int CW     = 3
) (
    input  logic              i_clock,
    input  logic              i_reset,
    input  logic              i_load,
    input  logic [W-1:0]      i_word,
    input  logic [CW-1:0]     i_nbytes,
    input  logic              i_tx_full,
    output logic              o_busy,
    output logic [DATA_W-1:0] o_tx_data,
    output logic              o_tx_wr
);
    logic [W-1:0]  shift;
    logic [CW-1:0] rem;
    logic          cool;
    assign o_busy = rem != '0;
    // cool skips the cycle after a push so the FIFO's updated full flag is seen
    always_ff @(posedge i_clock) begin
        if (i_reset) begin
            shift     <= '0;
            rem       <= '0;
            cool      <= 1'b0;
            o_tx_data <= '0;
            o_tx_wr   <= 1'b0;
        end else begin
            o_tx_wr <= 1'b0;
            cool    <= 1'b0;
            if (i_load) begin
                shift <= i_word;
                rem   <= i_nbytes;
            end else if (o_busy && !cool && !i_tx_full) begin
                o_tx_wr   <= 1'b1;
                o_tx_data <= shift[DATA_W-1:0];
                shift     <= shift >> DATA_W;
                rem       <= rem - 1'b1;
                cool      <= 1'b1;
            end
        end
    end
endmodule

// File: rtl/uart_debug_unit.sv
// uart_debug_unit: host command decoder for program load, run/step control and state dump
module uart_debug_unit
    import uart_dbg_pkg::*;
#(
    parameter int DATA_W  = 8,
    parameter int WORD_W  = 32,
    parameter int IMEM_AW = 8,
    parameter int REG_AW  = 5,
    parameter int N_REGS  = 32,
    parameter int DMEM_AW = 5,
    parameter int N_DMEM  = 32,
    parameter int PC_W    = 32
) (
    input  logic               i_clock,
    input  logic               i_reset,
    input  logic [DATA_W-1:0]  i_rx_data,
    input  logic               i_rx_empty,
    output logic               o_rx_rd,
    output logic [DATA_W-1:0]  o_tx_data,
    output logic               o_tx_wr,
    input  logic               i_tx_full,
    output logic               o_imem_wr,
    output logic [IMEM_AW-1:0] o_imem_addr,
    output logic [WORD_W-1:0]  o_imem_data,
    output logic [REG_AW-1:0]  o_reg_addr,
    input  logic [WORD_W-1:0]  i_reg_data,
    output logic [DMEM_AW-1:0] o_dmem_addr,
    input  logic [WORD_W-1:0]  i_dmem_data,
    input  logic [PC_W-1:0]    i_pc,
    input  logic               i_halt,
    output logic               o_pipe_en
);
    localparam int NB   = WORD_W / DATA_W;
    localparam int PB   = PC_W / DATA_W;
    localparam int SW   = (WORD_W > PC_W) ? WORD_W : PC_W;
    localparam int CW   = $clog2(SW / DATA_W + 1);
    localparam int BW   = $clog2(NB + 1);
    localparam int LAST = N_REGS + N_DMEM;
    localparam int IW   = $clog2(LAST + 1);

    state_e        state, state_d;
    logic          take, pop, imem_wr_d, pipe_en_d, ser_load, ser_busy, from_step;
    logic [SW-1:0] ser_word;
    logic [CW-1:0] ser_nbytes;
    logic [7:0]    ld_cnt;
    logic [BW-1:0] byte_cnt;
    logic [IW-1:0] idx;

    // o_rx_rd high means the FIFO head has not advanced yet
    assign take = !i_rx_empty && !o_rx_rd;

    always_ff @(posedge i_clock) begin
        if (i_reset) state <= IDLE;
        else state <= state_d;
    end

    always_comb begin
        state_d    = state;
        pop        = 1'b0;
        imem_wr_d  = 1'b0;
        pipe_en_d  = 1'b0;
        ser_load   = 1'b0;
        ser_word   = '0;
        ser_nbytes = '0;
        case (state)
            IDLE: if (take) begin
                pop     = 1'b1;
                state_d = (i_rx_data == DATA_W'(CMD_LOAD)) ? LD_SIZE :
                          (i_rx_data == DATA_W'(CMD_RUN))  ? RUN :
                          (i_rx_data == DATA_W'(CMD_STEP)) ? DBG : IDLE;
            end
            LD_SIZE: if (take) begin
                pop     = 1'b1;
                state_d = (i_rx_data == '0) ? LD_ACK : LD_BYTE;
            end
            LD_BYTE: if (take) begin
                pop     = 1'b1;
                state_d = (byte_cnt == BW'(NB - 1)) ? LD_WRITE : LD_BYTE;
            end
            LD_WRITE: begin
                imem_wr_d = 1'b1;
                state_d   = (ld_cnt == 8'd1) ? LD_ACK : LD_BYTE;
            end
            LD_ACK: if (!ser_busy) begin
                ser_load   = 1'b1;
                ser_word   = SW'(ACK_BYTE);
                ser_nbytes = CW'(1);
                state_d    = IDLE;
            end
            RUN: begin
                pipe_en_d = !i_halt;
                state_d   = i_halt ? DUMP_FETCH : RUN;
            end
            DBG: if (take) begin
                pop     = 1'b1;
                state_d = (i_rx_data == DATA_W'(CMD_NEXT)) ? STEP :
                          (i_rx_data == DATA_W'(CMD_END))  ? IDLE : DBG;
            end
            STEP: begin
                pipe_en_d = 1'b1;
                state_d   = DUMP_FETCH;
            end
            DUMP_FETCH: state_d = DUMP_SEND;
            DUMP_SEND: if (!ser_busy) begin
                ser_load   = 1'b1;
                ser_word   = (idx < IW'(N_REGS)) ? SW'(i_reg_data) :
                             (idx < IW'(LAST))   ? SW'(i_dmem_data) : SW'(i_pc);
                ser_nbytes = (idx == IW'(LAST)) ? CW'(PB) : CW'(NB);
                state_d    = (idx == IW'(LAST)) ? DUMP_END : DUMP_FETCH;
            end
            DUMP_END: if (!ser_busy) begin
                ser_load   = 1'b1;
                ser_word   = SW'(DUMP_TERM);
                ser_nbytes = CW'(1);
                state_d    = from_step ? DBG : IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    // address advances while the write strobe is visible, so the strobe sees a stable address
    always_ff @(posedge i_clock) begin
        if (i_reset) begin
            o_rx_rd     <= 1'b0;
            o_imem_wr   <= 1'b0;
            o_imem_addr <= '0;
            o_imem_data <= '0;
            o_reg_addr  <= '0;
            o_dmem_addr <= '0;
            o_pipe_en   <= 1'b0;
            ld_cnt      <= '0;
            byte_cnt    <= '0;
            idx         <= '0;
            from_step   <= 1'b0;
        end else begin
            o_rx_rd   <= pop;
            o_imem_wr <= imem_wr_d;
            o_pipe_en <= pipe_en_d;
            if (state == LD_SIZE && pop) begin
                ld_cnt   <= 8'(i_rx_data);
                byte_cnt <= '0;
            end
            if (state == LD_BYTE && pop) begin
                o_imem_data <= WORD_W'({i_rx_data, o_imem_data} >> DATA_W);
                byte_cnt    <= (byte_cnt == BW'(NB - 1)) ? '0 : byte_cnt + 1'b1;
            end
            if (state == LD_WRITE) ld_cnt <= ld_cnt - 8'd1;
            if (o_imem_wr) o_imem_addr <= o_imem_addr + 1'b1;
            if (state == LD_ACK) o_imem_addr <= '0;
            if (state == RUN) from_step <= 1'b0;
            if (state == STEP) from_step <= 1'b1;
            if (state == RUN || state == STEP) idx <= '0;
            if (state == DUMP_SEND && !ser_busy) idx <= idx + 1'b1;
            if (state == DUMP_FETCH && idx < IW'(N_REGS)) o_reg_addr <= REG_AW'(idx);
            if (state == DUMP_FETCH && idx >= IW'(N_REGS) && idx < IW'(LAST))
                o_dmem_addr <= DMEM_AW'(idx - IW'(N_REGS));
        end
    end

    word_serializer #(
        .DATA_W (DATA_W),
        .W      (SW),
        .CW     (CW)
    ) u_ser (
        .i_clock   (i_clock),
        .i_reset   (i_reset),
        .i_load    (ser_load),
        .i_word    (ser_word),
        .i_nbytes  (ser_nbytes),
        .i_tx_full (i_tx_full),
        .o_busy    (ser_busy),
        .o_tx_data (o_tx_data),
        .o_tx_wr   (o_tx_wr)
    );
endmodule

// File: tb/tb_uart_debug_unit.sv
// tb_uart_debug_unit: randomized host sessions checked against a byte-level model of load, run, step and dump
module tb_uart_debug_unit;
    localparam int N_REGS = 32;
    localparam int N_DMEM = 32;

    logic        i_clock = 1'b0;
    logic        i_reset = 1'b1;
    logic [7:0]  i_rx_data = 8'h00;
    logic        i_rx_empty = 1'b1;
    logic        o_rx_rd;
    logic [7:0]  o_tx_data;
    logic        o_tx_wr;
    logic        i_tx_full = 1'b0;
    logic        o_imem_wr;
    logic [7:0]  o_imem_addr;
    logic [31:0] o_imem_data;
    logic [4:0]  o_reg_addr;
    logic [31:0] i_reg_data;
    logic [4:0]  o_dmem_addr;
    logic [31:0] i_dmem_data;
    logic [31:0] i_pc;
    logic        i_halt = 1'b0;
    logic        o_pipe_en;

    logic [31:0] regs [N_REGS];
    logic [31:0] dmem [N_DMEM];
    logic [31:0] pc;
    logic [7:0]  host_bytes [1024];
    int          host_n = 0, rd_ptr = 0;
    logic [7:0]  got_tx [$];
    logic [7:0]  wr_addr_q [$];
    logic [31:0] wr_data_q [$];
    logic [7:0]  exp_q [$];
    int          pipe_cnt = 0, stall_err = 0, rx_err = 0;
    logic        full_prev = 1'b0, rx_rd_prev = 1'b0;
    int          n_checks = 0, n_fail = 0;

    always #5 i_clock = ~i_clock;

    assign i_reg_data  = regs[o_reg_addr];
    assign i_dmem_data = dmem[o_dmem_addr];
    assign i_pc        = pc;

    uart_debug_unit dut (
        .i_clock     (i_clock),
        .i_reset     (i_reset),
        .i_rx_data   (i_rx_data),
        .i_rx_empty  (i_rx_empty),
        .o_rx_rd     (o_rx_rd),
        .o_tx_data   (o_tx_data),
        .o_tx_wr     (o_tx_wr),
        .i_tx_full   (i_tx_full),
        .o_imem_wr   (o_imem_wr),
        .o_imem_addr (o_imem_addr),
        .o_imem_data (o_imem_data),
        .o_reg_addr  (o_reg_addr),
        .i_reg_data  (i_reg_data),
        .o_dmem_addr (o_dmem_addr),
        .i_dmem_data (i_dmem_data),
        .i_pc        (i_pc),
        .i_halt      (i_halt),
        .o_pipe_en   (o_pipe_en)
    );

    // RX FIFO model plus monitors for TX bytes, imem writes and enable cycles
    always @(negedge i_clock) begin
        if (o_tx_wr) got_tx.push_back(o_tx_data);
        if (o_imem_wr) begin
            wr_addr_q.push_back(o_imem_addr);
            wr_data_q.push_back(o_imem_data);
        end
        if (o_pipe_en) pipe_cnt++;
        if (i_tx_full && full_prev && o_tx_wr) stall_err++;
        if (o_rx_rd && rx_rd_prev) rx_err++;
        if (o_rx_rd) begin
            if (rd_ptr < host_n) rd_ptr++;
            else rx_err++;
        end
        full_prev  = i_tx_full;
        rx_rd_prev = o_rx_rd;
        i_rx_empty = (rd_ptr >= host_n);
        i_rx_data  = i_rx_empty ? 8'h00 : host_bytes[rd_ptr];
    end

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) begin
            @(negedge i_clock);
            #1;
        end
    endtask

    task automatic send(input logic [7:0] b);
        host_bytes[host_n] = b;
        host_n++;
    endtask

    task automatic wait_tx(input int target, input string tag);
        int c = 0;
        while (got_tx.size() < target && c < 5000) begin
            tick(1);
            c++;
        end
        check({tag, "_count"}, got_tx.size(), target);
    endtask

    task automatic wait_rx_drained(input string tag);
        int c = 0;
        while (rd_ptr < host_n && c < 500) begin
            tick(1);
            c++;
        end
        check({tag, "_drained"}, rd_ptr, host_n);
    endtask

    task automatic randomize_state();
        for (int i = 0; i < N_REGS; i++) regs[i] = $urandom;
        for (int i = 0; i < N_DMEM; i++) dmem[i] = $urandom;
        pc = $urandom;
    endtask

    task automatic build_exp();
        exp_q.delete();
        for (int r = 0; r < N_REGS; r++)
            for (int b = 0; b < 4; b++) exp_q.push_back(8'(regs[r] >> (8 * b)));
        for (int r = 0; r < N_DMEM; r++)
            for (int b = 0; b < 4; b++) exp_q.push_back(8'(dmem[r] >> (8 * b)));
        for (int b = 0; b < 4; b++) exp_q.push_back(8'(pc >> (8 * b)));
        exp_q.push_back(8'h5A);
    endtask

    task automatic cmp_dump(input int base, input string tag);
        check({tag, "_len"}, got_tx.size() - base, exp_q.size());
        for (int i = 0; i < exp_q.size() && base + i < got_tx.size(); i++)
            check(tag, got_tx[base + i], exp_q[i]);
    endtask

    task automatic check_zero_outs(input string tag);
        check(tag, {o_rx_rd, o_tx_wr, o_tx_data, o_imem_wr, o_imem_addr, o_pipe_en,
                    o_reg_addr, o_dmem_addr}, 64'd0);
        check({tag, "_word"}, o_imem_data, 64'd0);
    endtask

    initial begin
        #800000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int tb, wb, pc0, n, s0;
        logic [31:0] words [4];
        randomize_state();
        tick(3);
        check_zero_outs("reset");
        i_reset = 1'b0;
        tick(2);

        tb = got_tx.size(); wb = wr_addr_q.size();
        foreach (words[i]) words[i] = 0;
        send(8'h01); send(8'h02);
        send(8'h78); send(8'h56); send(8'h34); send(8'h12);
        send(8'hEF); send(8'hBE); send(8'hAD); send(8'hDE);
        wait_tx(tb + 1, "load");
        tick(5);
        check("load_nwr", wr_addr_q.size() - wb, 2);
        check("load_a0", wr_addr_q[wb], 0);
        check("load_d0", wr_data_q[wb], 32'h12345678);
        check("load_a1", wr_addr_q[wb + 1], 1);
        check("load_d1", wr_data_q[wb + 1], 32'hDEADBEEF);
        check("load_ack", got_tx[tb], 8'hA5);

        tb = got_tx.size(); wb = wr_addr_q.size();
        n = $urandom_range(1, 4);
        send(8'h01); send(8'(n));
        for (int i = 0; i < n; i++) begin
            words[i] = $urandom;
            for (int b = 0; b < 4; b++) send(8'(words[i] >> (8 * b)));
        end
        wait_tx(tb + 1, "rload");
        tick(5);
        check("rload_nwr", wr_addr_q.size() - wb, n);
        for (int i = 0; i < n; i++) begin
            check("rload_addr", wr_addr_q[wb + i], i);
            check("rload_data", wr_data_q[wb + i], words[i]);
        end
        check("rload_ack", got_tx[tb], 8'hA5);

        randomize_state(); build_exp();
        tb = got_tx.size(); pc0 = pipe_cnt;
        i_halt = 1'b0;
        send(8'h02);
        n = 0;
        while (pipe_cnt - pc0 < 10 && n < 300) begin
            tick(1);
            n++;
        end
        i_halt = 1'b1;
        tick(1);
        check("run_pipe_drop", o_pipe_en, 0);
        wait_tx(tb + exp_q.size(), "run_dump");
        tick(10);
        check("run_pipe_cycles", pipe_cnt - pc0, 10);
        cmp_dump(tb, "run_dump");

        randomize_state(); build_exp();
        tb = got_tx.size(); pc0 = pipe_cnt;
        send(8'h02);
        wait_tx(tb + exp_q.size(), "halted_run");
        tick(10);
        check("halted_run_pipe", pipe_cnt - pc0, 0);
        cmp_dump(tb, "halted_run");

        randomize_state(); build_exp();
        tb = got_tx.size(); pc0 = pipe_cnt;
        i_halt = 1'($urandom_range(0, 1));
        send(8'h03); send(8'h04);
        wait_tx(tb + exp_q.size(), "step");
        tick(10);
        check("step_pipe", pipe_cnt - pc0, 1);
        cmp_dump(tb, "step");

        tb = got_tx.size();
        send(8'h05);
        tick(20);
        send(8'h77);
        wait_rx_drained("stray");
        tick(20);
        check("end_stray_no_tx", got_tx.size() - tb, 0);

        tb = got_tx.size(); wb = wr_addr_q.size();
        send(8'h01); send(8'h00);
        wait_tx(tb + 1, "n0");
        tick(10);
        check("n0_ack", got_tx[tb], 8'hA5);
        check("n0_len", got_tx.size() - tb, 1);
        check("n0_nwr", wr_addr_q.size() - wb, 0);

        randomize_state(); build_exp();
        tb = got_tx.size();
        i_halt = 1'b1;
        send(8'h02);
        wait_tx(tb + 50, "bp_pre");
        i_tx_full = 1'b1;
        s0 = got_tx.size();
        tick(20);
        check("bp_hold", got_tx.size() - s0, 0);
        i_tx_full = 1'b0;
        wait_tx(tb + exp_q.size(), "bp_dump");
        tick(10);
        cmp_dump(tb, "bp_dump");

        send(8'h01); send(8'h01); send(8'hAA); send(8'hBB);
        wait_rx_drained("midload");
        tick(2);
        i_reset = 1'b1;
        tick(2);
        check_zero_outs("mid_reset");
        i_reset = 1'b0;
        tick(2);
        tb = got_tx.size(); wb = wr_addr_q.size();
        send(8'h01); send(8'h01); send(8'h11); send(8'h22); send(8'h33); send(8'h44);
        wait_tx(tb + 1, "reload");
        tick(5);
        check("reload_nwr", wr_addr_q.size() - wb, 1);
        check("reload_addr", wr_addr_q[wb], 0);
        check("reload_data", wr_data_q[wb], 32'h44332211);
        check("reload_ack", got_tx[tb], 8'hA5);

        check("stall_no_wr", stall_err, 0);
        check("rx_protocol", rx_err, 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
